bcd_nco_square: RTL

Parametrised successor to the six-digit key-driven square-wave generator. Holds a DIGITS-digit BCD frequency setpoint, edited by a movable digit cursor with inc/dec, carry/borrow and saturation. Converts the setpoint to binary sequentially, one digit per cycle. Drives a 50 %-duty square wave from a phase accumulator. Sits between the KEY_Debounce edge outputs and the SEG_Decoder/SEG_Scan display path.

---
 rtl/bcd_nco_pkg.sv | 64 ++++++
 rtl/bcd_nco_square_bcd_to_bin_seq.sv | 59 +++++
 rtl/bcd_nco_square.sv | 96 +++++++++
 3 files changed

// File: rtl/bcd_nco_pkg.sv
// Shared types and BCD digit-arithmetic helpers for the BCD-tuned square-wave NCO.
package bcd_nco_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX    = 4'd9;
   localparam bcd_digit_t BCD_MIN    = 4'd0;
   localparam int         MAX_DIGITS = 8;
   localparam int         BCD_MAX_W  = 4 * MAX_DIGITS;

   typedef enum logic {IDLE, CONV} conv_state_t;

   typedef struct packed {
      logic [BCD_MAX_W-1:0] vec;
      logic                 flag;
   } bcd_res_t;

   // Add one unit at digit idx; flag reports a carry out of digit ndig-1.
   function automatic bcd_res_t bcd_inc_at(input logic [BCD_MAX_W-1:0] v,
                                           input int idx, input int ndig);
      bcd_res_t   r;
      logic       c;
      bcd_digit_t d;
      r.vec = v;
      c     = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i >= idx && i < ndig && c) begin
            d = r.vec[4*i +: 4];
            if (d == BCD_MAX) begin
               r.vec[4*i +: 4] = BCD_MIN;
            end else begin
               r.vec[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end
      end
      r.flag = c;
      return r;
   endfunction

   // Subtract one unit at digit idx; flag reports a borrow out of digit ndig-1.
   function automatic bcd_res_t bcd_dec_at(input logic [BCD_MAX_W-1:0] v,
                                           input int idx, input int ndig);
      bcd_res_t   r;
      logic       b;
      bcd_digit_t d;
      r.vec = v;
      b     = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i >= idx && i < ndig && b) begin
            d = r.vec[4*i +: 4];
            if (d == BCD_MIN) begin
               r.vec[4*i +: 4] = BCD_MAX;
            end else begin
               r.vec[4*i +: 4] = d - 4'd1;
               b = 1'b0;
            end
         end
      end
      r.flag = b;
      return r;
   endfunction

endpackage

// File: rtl/bcd_nco_square_bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, MSD first, one digit per cycle.
module bcd_to_bin_seq
   import bcd_nco_pkg::*;
#(
   parameter int DIGITS = 6,
   parameter int BIN_W  = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_value,
   output logic [BIN_W-1:0]      freq_bin,
   output logic                  busy
);

   localparam int IDX_W = $clog2(DIGITS);

   conv_state_t      state_q;
   logic [IDX_W-1:0] idx_q;
   logic [BIN_W-1:0] acc_q;
   logic [BIN_W-1:0] acc_d;
   logic [BIN_W-1:0] freq_q;
   logic             busy_q;
   bcd_digit_t       digit;

   always_comb begin
      digit = bcd_value[4*int'(idx_q) +: 4];
      acc_d = acc_q * BIN_W'(10) + BIN_W'(digit);
   end

   // A new start always wins, so an edit mid-pass restarts from the MSD and
   // freq_q only ever sees a completed pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         freq_q  <= BIN_W'(1);
         busy_q  <= 1'b0;
      end else if (start) begin
         state_q <= CONV;
         idx_q   <= IDX_W'(DIGITS - 1);
         acc_q   <= '0;
         busy_q  <= 1'b1;
      end else if (state_q == CONV) begin
         acc_q <= acc_d;
         idx_q <= idx_q - 1'b1;
         if (idx_q == '0) begin
            freq_q  <= acc_d;
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   assign freq_bin = freq_q;
   assign busy     = busy_q;

endmodule

// File: rtl/bcd_nco_square.sv
// Key-edited BCD frequency setpoint driving a phase-accumulator square wave.
module bcd_nco_square
   import bcd_nco_pkg::*;
#(
   parameter  int DIGITS = 6,
   parameter  int ACC_W  = 32,
   parameter  int TUNE_K = 86,
   localparam int BIN_W  = $clog2(10**DIGITS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        inc,
   input  logic                        dec,
   input  logic                        cur_left,
   input  logic                        cur_right,
   output logic [4*DIGITS-1:0]         bcd_value,
   output logic [$clog2(DIGITS)-1:0]   cursor,
   output logic [BIN_W-1:0]            freq_bin,
   output logic                        busy,
   output logic                        square
);

   localparam int                CUR_W = $clog2(DIGITS);
   localparam int                BCD_W = 4 * DIGITS;
   localparam logic [BCD_W-1:0]  ALL9  = {DIGITS{4'h9}};

   logic [BCD_W-1:0] bcd_d, bcd_q;
   logic [CUR_W-1:0] cursor_d, cursor_q;
   logic [ACC_W-1:0] tune_d, tune_q;
   logic [ACC_W-1:0] acc_d, acc_q;
   logic             square_d, square_q;
   logic             start;
   bcd_res_t         inc_r, dec_r;

   always_comb begin
      inc_r = bcd_inc_at(32'(bcd_q), int'(cursor_q), DIGITS);
      dec_r = bcd_dec_at(32'(bcd_q), int'(cursor_q), DIGITS);
      bcd_d = bcd_q;
      // Overflow pins at all nines; underflow or zero pins at one.
      if (inc && !dec) begin
         bcd_d = inc_r.flag ? ALL9 : BCD_W'(inc_r.vec);
      end else if (dec && !inc) begin
         bcd_d = (dec_r.flag || dec_r.vec == '0) ? BCD_W'(1) : BCD_W'(dec_r.vec);
      end
      start = (bcd_d != bcd_q);
   end

   always_comb begin
      cursor_d = cursor_q;
      if (cur_left && !cur_right) begin
         cursor_d = (cursor_q == CUR_W'(DIGITS - 1)) ? '0 : cursor_q + 1'b1;
      end else if (cur_right && !cur_left) begin
         cursor_d = (cursor_q == '0) ? CUR_W'(DIGITS - 1) : cursor_q - 1'b1;
      end
   end

   // Product modulo 2^ACC_W, so operands can be truncated before multiplying.
   always_comb begin
      tune_d   = ACC_W'(freq_bin) * ACC_W'(TUNE_K);
      acc_d    = acc_q + tune_q;
      square_d = acc_q[ACC_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q    <= BCD_W'(1);
         cursor_q <= '0;
         tune_q   <= ACC_W'(TUNE_K);
         acc_q    <= '0;
         square_q <= 1'b0;
      end else begin
         bcd_q    <= bcd_d;
         cursor_q <= cursor_d;
         tune_q   <= tune_d;
         acc_q    <= acc_d;
         square_q <= square_d;
      end
   end

   bcd_to_bin_seq #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) u_conv (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bcd_value (bcd_q),
      .freq_bin  (freq_bin),
      .busy      (busy)
   );

   assign bcd_value = bcd_q;
   assign cursor    = cursor_q;
   assign square    = square_q;

endmodule
